mc_mem_responder: RTL

//  Unified instruction/data memory responder for the multicycle RV32I core.

---
 rtl/mc_mem_responder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_mem_responder.sv
// Unified instruction/data memory responder for the multicycle RV32I core.
// Word-organised RAM with programmable wait states, store lane merge and load extension.
module mc_mem_responder #(
  parameter int ADDR_WIDTH    = 10,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [7:0] RD_CNT = 8'(READ_LATENCY - 1);
  localparam logic [7:0] WR_CNT = 8'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_r, state_next_s;
  logic [7:0]  cnt_r, cnt_next_s;
  logic        write_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        resp_ready_r;
  logic [31:0] resp_rdata_r;
  logic        resp_error_r;
  logic        busy_r;

  logic        capture_s;
  logic        finish_s;
  logic        err_s;
  logic [31:0] rd_word_s;
  logic [31:0] load_data_s;
  logic [31:0] merged_s;

  logic [31:0] mem [0:DEPTH-1];

  // Undefined access types are errors for both directions; stores only know SB/SH/SW.
  function automatic logic access_error(input logic wr, input logic [2:0] f3,
                                        input logic [31:0] a);
    logic bad_f3;
    logic misal;
    logic oor;
    bad_f3 = 1'b0;
    misal  = 1'b0;
    case (f3)
      3'b000: begin bad_f3 = 1'b0; misal = 1'b0;              end
      3'b001: begin bad_f3 = 1'b0; misal = a[0];              end
      3'b010: begin bad_f3 = 1'b0; misal = (a[1:0] != 2'b00); end
      3'b100: begin bad_f3 = wr;   misal = 1'b0;              end
      3'b101: begin bad_f3 = wr;   misal = a[0];              end
      default: begin bad_f3 = 1'b1; misal = 1'b0;             end
    endcase
    oor = |a[31:ADDR_WIDTH+2];
    return bad_f3 | misal | oor;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (f3)
      3'b000: begin
        case (lo)
          2'b00:   r[7:0]   = wd[7:0];
          2'b01:   r[15:8]  = wd[7:0];
          2'b10:   r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      3'b001: begin
        if (lo[1]) r[31:16] = wd[15:0];
        else       r[15:0]  = wd[15:0];
      end
      3'b010:  r = wd;
      default: r = old;
    endcase
    return r;
  endfunction

  assign err_s       = access_error(write_r, funct3_r, addr_r);
  assign rd_word_s   = mem[addr_r[ADDR_WIDTH+1:2]];
  assign load_data_s = load_extend(funct3_r, addr_r[1:0], rd_word_s);
  assign merged_s    = store_merge(funct3_r, addr_r[1:0], rd_word_s, wdata_r);

  // Next-state, counter and strobe decode.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    capture_s    = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          capture_s    = 1'b1;
          cnt_next_s   = req_write ? WR_CNT : RD_CNT;
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 8'd0) begin
          finish_s     = 1'b1;
          state_next_s = ST_RESP;
        end else begin
          cnt_next_s   = cnt_r - 8'd1;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Request capture on acceptance in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_r  <= 1'b0;
      funct3_r <= 3'b000;
      addr_r   <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
    end else if (capture_s) begin
      write_r  <= req_write;
      funct3_r <= req_funct3;
      addr_r   <= req_addr;
      wdata_r  <= req_wdata;
    end
  end

  // Registered response; data and error hold between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_ready_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_error_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      resp_ready_r <= finish_s;
      busy_r       <= (state_next_s != ST_IDLE);
      if (finish_s) begin
        resp_error_r <= err_s;
        resp_rdata_r <= (write_r || err_s) ? 32'h0000_0000 : load_data_s;
      end
    end
  end

  // RAM commit; async reset clears state so an interrupted store never reaches here.
  always_ff @(posedge clk) begin
    if (finish_s && write_r && !err_s) begin
      mem[addr_r[ADDR_WIDTH+1:2]] <= merged_s;
    end
  end

  assign resp_ready = resp_ready_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_error = resp_error_r;
  assign busy       = busy_r;

endmodule
